// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and helpers for the wait-state data memory.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int c_cnt_w = 4;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_array
// Purpose  : DEPTH x DATA_W storage, byte-lane writes, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_array
    import mem_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 64,
    localparam int IDX_W  = idx_width(DEPTH),
    localparam int LANES  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [IDX_W-1:0]  idx,
    input  logic [LANES-1:0]  byte_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    // Read port returns to zero whenever no read is being committed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (wr_en) begin
                for (int b = 0; b < LANES; b++) begin
                    if (byte_en[b]) begin
                        r_mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                    end
                end
            end
            r_rd_data <= rd_en ? r_mem[idx] : '0;
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/data_memory_ws.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_ws
// Purpose  : MEM-stage data memory with wait states, ready handshake, faults.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_ws
    import mem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   dataIn,
    output logic [DATA_W-1:0]   dataOut,
    output logic                ready,
    output logic                err
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam int LANES = DATA_W / 8;

    localparam logic [c_cnt_w-1:0] c_wait  = c_cnt_w'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]    c_base  = (ADDR_W+1)'(BASE_ADDR);
    localparam logic [ADDR_W:0]    c_limit = (ADDR_W+1)'(BASE_ADDR + 4*DEPTH);
    localparam logic [ADDR_W-1:0]  c_base_a = ADDR_W'(BASE_ADDR);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [LANES-1:0]     r_be;
    logic                 r_is_write;
    logic                 r_err;
    logic                 w_capture;
    logic                 w_commit;
    logic                 w_fault;
    logic                 w_mem_wr;
    logic                 w_mem_rd;
    logic [IDX_W-1:0]     w_idx;

    // Offset is formed at full address width before truncating to the index
    assign w_idx   = IDX_W'((r_addr - c_base_a) >> 2);
    assign w_fault = ({1'b0, r_addr} < c_base) ||
                     ({1'b0, r_addr} >= c_limit) ||
                     (r_addr[1:0] != 2'b00);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_r_en || mem_w_en) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = c_wait;
                    w_state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_commit     = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_mem_wr = w_commit &&  r_is_write && !w_fault;
    assign w_mem_rd = w_commit && !r_is_write && !w_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_commit && w_fault;
            if (w_capture) begin
                r_addr     <= address;
                r_wdata    <= dataIn;
                r_be       <= byte_en;
                r_is_write <= mem_w_en;
            end
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_mem_wr),
        .rd_en   (w_mem_rd),
        .idx     (w_idx),
        .byte_en (r_be),
        .wr_data (r_wdata),
        .rd_data (dataOut)
    );

    assign ready = (r_state == DONE);
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_ws
// Purpose  : Directed self-checking bench for data_memory_ws (default and zero-wait).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst0;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [3:0]  byte_en;
    logic [31:0] address;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [31:0] dataOut0;
    logic        ready;
    logic        ready0;
    logic        err;
    logic        err0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_memory_ws dut (
        .clk      (clk),
        .rst      (rst),
        .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en),
        .byte_en  (byte_en),
        .address  (address),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .ready    (ready),
        .err      (err)
    );

    data_memory_ws #(
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk      (clk),
        .rst      (rst0),
        .mem_r_en (mem_r_en),
        .mem_w_en (mem_w_en),
        .byte_en  (byte_en),
        .address  (address),
        .dataIn   (dataIn),
        .dataOut  (dataOut0),
        .ready    (ready0),
        .err      (err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered just after a posedge; that cycle is T. Latency counts cycles from T to ready.
    task automatic access(input logic sel, input logic re, input logic we,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int exp_lat,
                          input logic [31:0] exp_data, input logic exp_err,
                          input string tag);
        int          n;
        logic        seen;
        logic [31:0] got_data;
        logic        got_err;
        mem_r_en = re;
        mem_w_en = we;
        address  = addr;
        dataIn   = data;
        byte_en  = be;
        n        = 0;
        seen     = 1'b0;
        got_data = '0;
        got_err  = 1'b0;
        while (!seen && n <= 30) begin
            @(negedge clk);
            if (sel ? ready0 : ready) begin
                seen     = 1'b1;
                got_data = sel ? dataOut0 : dataOut;
                got_err  = sel ? err0 : err;
            end else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " data"}, got_data, exp_data);
        check({tag, " err"}, {31'b0, got_err}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rst0     = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        byte_en  = 4'h0;
        address  = '0;
        dataIn   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready",   {31'b0, ready}, 32'd0);
        check("reset err",     {31'b0, err},   32'd0);
        check("reset dataOut", dataOut,        32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Default instance: 2 wait cycles, latency 4
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 4'h0, 4, 32'h0, 1'b0, "rd1024 after reset");
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'hF, 4, 32'h0, 1'b0, "wr1028 full");
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 4'h0, 4, 32'hDEADBEEF, 1'b0, "rd1028 full");
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'h0000AA00, 4'b0010, 4, 32'h0, 1'b0, "wr1028 lane1");
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 4'h0, 4, 32'hDEADAAEF, 1'b0, "rd1028 merged");
        access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hFFFFFFFF, 4'h0, 4, 32'h0, 1'b0, "wr1028 no lanes");
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 4'h0, 4, 32'hDEADAAEF, 1'b0, "rd1028 unchanged");

        // Faults: range limit, misalignment, below base
        access(1'b0, 1'b0, 1'b1, 32'd1280, 32'h12345678, 4'hF, 4, 32'h0, 1'b1, "wr1280 range");
        access(1'b0, 1'b0, 1'b1, 32'd1030, 32'h12345678, 4'hF, 4, 32'h0, 1'b1, "wr1030 misalign");
        access(1'b0, 1'b1, 1'b0, 32'd1020, 32'h0, 4'h0, 4, 32'h0, 1'b1, "rd1020 below");
        access(1'b0, 1'b1, 1'b0, 32'd1280, 32'h0, 4'h0, 4, 32'h0, 1'b1, "rd1280 range");
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, 4'h0, 4, 32'h0, 1'b0, "rd1024 no alias");
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, 4'h0, 4, 32'hDEADAAEF, 1'b0, "rd1028 no misalign wr");
        access(1'b0, 1'b0, 1'b1, 32'd1276, 32'h11223344, 4'hF, 4, 32'h0, 1'b0, "wr1276 last");
        access(1'b0, 1'b1, 1'b0, 32'd1276, 32'h0, 4'h0, 4, 32'h11223344, 1'b0, "rd1276 last");

        // Reset during the first ACCESS cycle of a write
        mem_w_en = 1'b1;
        address  = 32'd1032;
        dataIn   = 32'hCAFEF00D;
        byte_en  = 4'hF;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        mem_w_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst ready",   {31'b0, ready}, 32'd0);
        check("midrst err",     {31'b0, err},   32'd0);
        check("midrst dataOut", dataOut,        32'd0);
        @(posedge clk);
        #1;
        access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, 4'h0, 4, 32'h0, 1'b0, "rd1032 after midrst");
        access(1'b0, 1'b1, 1'b0, 32'd1276, 32'h0, 4'h0, 4, 32'h0, 1'b0, "rd1276 cleared");

        // Zero-wait instance; default instance parked in reset
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0;
        access(1'b1, 1'b1, 1'b1, 32'd1024, 32'h55AA1234, 4'hF, 2, 32'h0, 1'b0, "w0 rw both 1024");
        access(1'b1, 1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 4'hF, 2, 32'h0, 1'b0, "w0 wr1028");
        // Back-to-back reads: second request is already present in the IDLE cycle after DONE
        mem_r_en = 1'b1;
        access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, 4'h0, 2, 32'h55AA1234, 1'b0, "w0 rd1024");
        access(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'h0, 2, 32'h0BADF00D, 1'b0, "w0 rd1028");
        access(1'b1, 1'b1, 1'b0, 32'd1031, 32'h0, 4'h0, 2, 32'h0, 1'b1, "w0 rd1031 misalign");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
